// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader: FSM encoding, buffer sizing,
// read latency and the default word/address widths shared with the BRAM.
package bram_stream_reader_pkg;

    localparam int RAM_WIDTH_DEF  = 13;
    localparam int NB_ADDRESS_DEF = 10;
    localparam int BUF_DEPTH      = 4;
    localparam int READ_LATENCY   = 2;
    localparam int CNT_W          = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bram_reader_fifo.sv
// Small synchronous output buffer for the BRAM stream reader; the head entry
// is presented combinationally so the stream data stays put while stalled.
module bram_reader_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH = RAM_WIDTH_DEF,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             i_CLK,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side controller turning a base/length request into a valid/ready word
// stream from a BRAM with registered read. Optional BRAM_READER_STALL_CNT_EN.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
    parameter int NB_ADDRESS = NB_ADDRESS_DEF
) (
    input  logic                  i_CLK,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_ADDRESS-1:0] i_baseAdd,
    input  logic [NB_ADDRESS:0]   i_length,
    output logic [NB_ADDRESS-1:0] o_readAdd,
    input  logic [RAM_WIDTH-1:0]  i_data,
    output logic [RAM_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
`ifdef BRAM_READER_STALL_CNT_EN
    output logic [15:0]           o_stallCnt,
`endif
    output logic                  o_done
);

    localparam int TAG_STAGES = READ_LATENCY - 1;

    state_t                r_state;
    logic [NB_ADDRESS-1:0] r_readAdd;
    logic [NB_ADDRESS:0]   r_remaining;
    logic [TAG_STAGES-1:0] r_tag;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_W-1:0]      w_count;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [CNT_W:0]        w_inflight;
    logic [CNT_W:0]        w_occ;

    assign w_pop  = !w_empty && i_ready;
    assign w_push = r_tag[TAG_STAGES-1];

    // Reads issued but not yet landed in the buffer
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < TAG_STAGES; i++) begin
            w_inflight = w_inflight + {{CNT_W{1'b0}}, r_tag[i]};
        end
    end

    // A slot is reserved for every in-flight read, so the buffer cannot overflow
    assign w_occ   = {1'b0, w_count} + w_inflight - {{CNT_W{1'b0}}, w_pop};
    assign w_issue = (r_state == ST_RUN) && (r_remaining != '0)
                     && (w_occ < (CNT_W+1)'(BUF_DEPTH));

    // Control FSM, address counter and capture-tag pipeline
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_readAdd   <= '0;
            r_remaining <= '0;
            r_tag       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_tag[0] <= w_issue;
            for (int i = 1; i < TAG_STAGES; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_issue) begin
                r_readAdd   <= r_readAdd + NB_ADDRESS'(1);
                r_remaining <= r_remaining - (NB_ADDRESS+1)'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_readAdd   <= i_baseAdd;
                        r_remaining <= i_length;
                        r_busy      <= 1'b1;
                        if (i_length == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue && (r_remaining == (NB_ADDRESS+1)'(1))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && (w_count == CNT_W'(1)) && (w_inflight == '0)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    bram_reader_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .i_CLK   (i_CLK),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_count (w_count),
        .o_empty (w_empty)
    );

`ifdef BRAM_READER_STALL_CNT_EN
    logic [15:0] r_stallCnt;

    // Saturating count of backpressured cycles, restarted by each accepted start
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_stallCnt <= 16'd0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_stallCnt <= 16'd0;
        end else if (!w_empty && !i_ready && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end else begin
            r_stallCnt <= r_stallCnt;
        end
    end

    assign o_stallCnt = r_stallCnt;
`endif

    assign o_readAdd = r_readAdd;
    assign o_valid   = !w_empty;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed, table-driven bench for bram_stream_reader with an address-valued
// registered-read BRAM model.
module tb_bram_stream_reader;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [9:0]  i_baseAdd;
    logic [10:0] i_length;
    logic [9:0]  o_readAdd;
    logic [12:0] i_data;
    logic [12:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;
`ifdef BRAM_READER_STALL_CNT_EN
    logic [15:0] o_stallCnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] length;
        logic [31:0] pat;
        int          poke_cyc;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    bram_stream_reader dut (
        .i_CLK     (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_baseAdd (i_baseAdd),
        .i_length  (i_length),
        .o_readAdd (o_readAdd),
        .i_data    (i_data),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_busy    (o_busy),
`ifdef BRAM_READER_STALL_CNT_EN
        .o_stallCnt(o_stallCnt),
`endif
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM with registered read; each word holds its own address
    always @(posedge clk) i_data <= {3'b000, o_readAdd};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0]  exp_addr;
        logic [12:0] prev_data;
        logic        prev_stall;
        bit          fin;
        int          cyc;
        int          got;
        int          first_v;
        int          last_hs;
        int          done_cyc;
        int          stalls;
        exp_addr = v.base; prev_data = '0; prev_stall = 1'b0; fin = 1'b0;
        got = 0; first_v = -1; last_hs = -1; done_cyc = -1; stalls = 0;
        @(negedge clk);
        i_start = 1'b1; i_baseAdd = v.base; i_length = v.length; i_ready = v.pat[0];
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        if (v.length != 11'd0) chk("first_addr", 32'(o_readAdd), 32'(v.base));
        cyc = 1;
        while (!fin && cyc < 300) begin
            if (cyc > 1) @(negedge clk);
            i_ready = v.pat[cyc % 32];
            if (cyc == v.poke_cyc) begin
                i_start = 1'b1; i_baseAdd = 10'd500; i_length = 11'd9;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(prev_data));
            end
            if (o_valid) begin
                if (first_v < 0) first_v = cyc;
                if (i_ready) begin
                    chk("word", 32'(o_data), {19'd0, 3'b000, exp_addr});
                    exp_addr = exp_addr + 10'd1;
                    got++;
                    last_hs = cyc;
                end else begin
                    stalls++;
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            cyc++;
        end
        i_start = 1'b0;
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        chk("word_count", 32'(got), 32'(v.length));
        if (v.length == 11'd0) begin
            chk("zero_len_done", 32'(done_cyc), 32'd1);
            chk("zero_len_novalid", 32'(first_v), 32'hFFFF_FFFF);
        end else begin
            chk("first_valid_cyc", 32'(first_v), 32'd3);
            chk("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
        end
        if (v.exp_done >= 0) chk("done_cyc", 32'(done_cyc), 32'(v.exp_done));
`ifdef BRAM_READER_STALL_CNT_EN
        chk("stall_cnt", 32'(o_stallCnt), 32'(stalls));
`endif
        @(negedge clk);
        i_ready = 1'b1;
        chk("busy_after_done", 32'(o_busy), 32'd0);
        chk("done_pulse_width", 32'(o_done), 32'd0);
    endtask

    initial begin
        vec_t fresh;
        vecs[0] = '{10'd0,    11'd8,  32'hFFFF_FFFF, 0, 11};
        vecs[1] = '{10'd1020, 11'd6,  32'hFFFF_FFFF, 0, 9};
        vecs[2] = '{10'd200,  11'd16, 32'hB3A5_6C2D, 0, -1};
        vecs[3] = '{10'd7,    11'd0,  32'hFFFF_FFFF, 0, 1};
        vecs[4] = '{10'd100,  11'd4,  32'hFFFF_FFFF, 2, 7};
        vecs[5] = '{10'd1023, 11'd1,  32'hFFFF_FFF0, 0, 5};

        i_rst = 1'b1; i_start = 1'b0; i_baseAdd = '0; i_length = '0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_addr",  32'(o_readAdd), 32'd0);
        chk("rst_data",  32'(o_data),    32'd0);
        chk("rst_valid", 32'(o_valid),   32'd0);
        chk("rst_busy",  32'(o_busy),    32'd0);
        chk("rst_done",  32'(o_done),    32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        // Reset two cycles after the first word of a run
        @(negedge clk);
        i_start = 1'b1; i_baseAdd = 10'd40; i_length = 11'd10; i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_first_valid", 32'(o_valid), 32'd1);
        chk("mr_first_word",  32'(o_data),  32'd40);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("mr_addr",  32'(o_readAdd), 32'd0);
        chk("mr_data",  32'(o_data),    32'd0);
        chk("mr_valid", 32'(o_valid),   32'd0);
        chk("mr_busy",  32'(o_busy),    32'd0);
        chk("mr_done",  32'(o_done),    32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mr_quiet_valid", 32'(o_valid), 32'd0);
            chk("mr_quiet_done",  32'(o_done),  32'd0);
        end
        fresh = '{10'd5, 11'd3, 32'hFFFF_FFFF, 0, 6};
        run_vec(fresh);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
